move_input_ctrl: RTL and testbench

// Producer end of the move-command interface for the 2048 game. Takes the four raw

---
 rtl/move_input_ctrl.sv | 128 ++++++++++++
 tb/tb_move_input_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/move_input_ctrl.sv
// Move-command producer for the 2048 game: synchronizes and debounces four active-low
// push buttons and issues one valid/ready move command per physical press.
module move_input_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  buttons,
   input  logic        enable,
   input  logic        move_ready,
   output logic        move_valid,
   output logic [1:0]  move_dir,
   output logic [15:0] move_count,
   output logic [1:0]  state
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      DEBOUNCE     = 2'd1,
      ISSUE        = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    sync1_q, sync2_q;
   logic [3:0]    cap_q, cap_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          move_valid_q, move_valid_d;
   logic [1:0]    move_dir_q, move_dir_d;
   logic [15:0]   move_count_q, move_count_d;
   logic [3:0]    pressed;

   function automatic logic [1:0] onehot_index(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   assign pressed = ~sync2_q;

   always_comb begin
      // NOTE: every _d starts from its _q so no path through the case leaves a latch.
      state_d      = state_q;
      cap_d        = cap_q;
      cnt_d        = cnt_q;
      move_valid_d = move_valid_q;
      move_dir_d   = move_dir_q;
      move_count_d = move_count_q;

      unique case (state_q)
         IDLE: begin
            if (!$onehot0(pressed)) begin
               state_d = WAIT_RELEASE;
            end else if (enable && (pressed != 4'b0000)) begin
               cap_d   = pressed;
               state_d = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (pressed != cap_q) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d      = ISSUE;
               move_dir_d   = onehot_index(cap_q);
               move_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ISSUE: begin
            // Command stays up regardless of enable or buttons until it is taken.
            if (move_ready) begin
               move_valid_d = 1'b0;
               move_count_d = move_count_q + 16'd1;
               state_d      = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (pressed != 4'b0000) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Each state measures its own stability window from zero.
      if (state_d != state_q) cnt_d = '0;
   end

   // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q      <= 4'b1111;
         sync2_q      <= 4'b1111;
         state_q      <= IDLE;
         cap_q        <= 4'b0000;
         cnt_q        <= '0;
         move_valid_q <= 1'b0;
         move_dir_q   <= 2'b00;
         move_count_q <= 16'h0000;
      end else begin
         sync1_q      <= buttons;
         sync2_q      <= sync1_q;
         state_q      <= state_d;
         cap_q        <= cap_d;
         cnt_q        <= cnt_d;
         move_valid_q <= move_valid_d;
         move_dir_q   <= move_dir_d;
         move_count_q <= move_count_d;
      end
   end

   assign move_valid = move_valid_q;
   assign move_dir   = move_dir_q;
   assign move_count = move_count_q;
   assign state      = state_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Scoreboard bench for move_input_ctrl with a 4-cycle debounce window: expected move
// directions are queued at stimulus time and popped on every accepted handshake.
module tb_move_input_ctrl;

   logic        clk;
   logic        rst;
   logic [3:0]  buttons;
   logic        enable;
   logic        move_ready;
   logic        move_valid;
   logic [1:0]  move_dir;
   logic [15:0] move_count;
   logic [1:0]  state;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [1:0]  exp_q[$];
   logic [1:0]  exp_dir;

   move_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .buttons    (buttons),
      .enable     (enable),
      .move_ready (move_ready),
      .move_valid (move_valid),
      .move_dir   (move_dir),
      .move_count (move_count),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 2 time units after a rising edge; outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_accept(input string tag);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
      check({tag, "_accepted"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // Scoreboard: every completed handshake must match a queued expectation.
   always @(negedge clk) begin
      if (rst && move_valid && move_ready) begin
         check("cmd_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp_dir = exp_q.pop_front();
            check("cmd_dir", 32'(move_dir), 32'(exp_dir));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b0;
      buttons    = 4'b1111;
      enable     = 1'b1;
      move_ready = 1'b0;
      step();
      step();
      check("rst_valid", 32'(move_valid), 32'd0);
      check("rst_dir",   32'(move_dir),   32'd0);
      check("rst_count", 32'(move_count), 32'd0);
      check("rst_state", 32'(state),      32'd0);
      rst = 1'b1;
      step();

      // 1: clean right press, ready already high -> one-cycle pulse after edge 7
      move_ready = 1'b1;
      buttons    = 4'b1110;
      exp_q.push_back(2'd0);
      for (int k = 1; k <= 9; k++) begin
         step();
         check($sformatf("t1_valid_e%0d", k), 32'(move_valid), 32'(k == 7));
         if (k == 7) check("t1_dir", 32'(move_dir), 32'd0);
         if (k == 8) begin
            check("t1_state_wait", 32'(state), 32'd3);
            check("t1_count", 32'(move_count), 32'd1);
         end
      end
      repeat (11) step();
      check("t1_no_repeat", 32'(exp_q.size()), 32'd0);
      buttons = 4'b1111;
      repeat (10) step();
      check("t1_state_idle", 32'(state), 32'd0);

      // 2: left press, consumer stalls for 10 cycles
      move_ready = 1'b0;
      buttons    = 4'b0111;
      exp_q.push_back(2'd3);
      repeat (7) step();
      for (int i = 0; i < 10; i++) begin
         check("t2_valid_held", 32'(move_valid), 32'd1);
         check("t2_dir_stable", 32'(move_dir), 32'd3);
         step();
      end
      move_ready = 1'b1;
      step();
      check("t2_valid_drop", 32'(move_valid), 32'd0);
      check("t2_count", 32'(move_count), 32'd2);
      check("t2_state", 32'(state), 32'd3);
      buttons = 4'b1111;
      repeat (10) step();

      // 3: bounce on up button, then a stable press
      buttons = 4'b1101;
      step();
      step();
      buttons = 4'b1111;
      step();
      buttons = 4'b1101;
      for (int k = 4; k <= 9; k++) begin
         step();
         check($sformatf("t3_no_valid_e%0d", k), 32'(move_valid), 32'd0);
         if (k == 5) check("t3_bounce_idle", 32'(state), 32'd0);
      end
      exp_q.push_back(2'd1);
      wait_accept("t3");
      check("t3_count", 32'(move_count), 32'd3);
      buttons = 4'b1111;
      repeat (10) step();

      // 4: chord is ignored; release window is exactly four cycles
      buttons = 4'b1100;
      repeat (3) step();
      check("t4_chord_wait", 32'(state), 32'd3);
      repeat (5) step();
      check("t4_chord_hold", 32'(state), 32'd3);
      check("t4_no_valid", 32'(move_valid), 32'd0);
      buttons = 4'b1111;
      repeat (5) step();
      check("t4_still_wait", 32'(state), 32'd3);
      step();
      check("t4_idle", 32'(state), 32'd0);
      buttons = 4'b1110;
      exp_q.push_back(2'd0);
      wait_accept("t4");
      check("t4_count", 32'(move_count), 32'd4);
      buttons = 4'b1111;
      repeat (10) step();

      // 5: press while disabled, then enable with button still held
      enable  = 1'b0;
      buttons = 4'b1011;
      repeat (10) step();
      check("t5_disabled_valid", 32'(move_valid), 32'd0);
      check("t5_disabled_state", 32'(state), 32'd0);
      enable = 1'b1;
      exp_q.push_back(2'd2);
      wait_accept("t5");
      check("t5_count", 32'(move_count), 32'd5);
      buttons = 4'b1111;
      repeat (10) step();

      // 6: asynchronous reset in the middle of ISSUE
      move_ready = 1'b0;
      buttons    = 4'b1110;
      exp_q.push_back(2'd0);
      repeat (7) step();
      check("t6_issue_valid", 32'(move_valid), 32'd1);
      #1 rst = 1'b0;
      #1;
      check("t6_rst_valid", 32'(move_valid), 32'd0);
      check("t6_rst_count", 32'(move_count), 32'd0);
      check("t6_rst_state", 32'(state), 32'd0);
      exp_q.delete();
      buttons = 4'b1111;
      step();
      step();
      rst = 1'b1;
      step();

      // 7: counter wrap from 0xFFFF
      step();
      force dut.move_count_q = 16'hFFFF;
      step();
      release dut.move_count_q;
      step();
      check("t7_preload", 32'(move_count), 32'h0000FFFF);
      move_ready = 1'b1;
      buttons    = 4'b0111;
      exp_q.push_back(2'd3);
      wait_accept("t7");
      check("t7_wrap", 32'(move_count), 32'd0);
      buttons = 4'b1111;
      repeat (10) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
